// File: rtl/cplx_pkg.sv
// Shared types and helpers for the fixed-point complex divider.
// Components are Q11.12 two's complement, packed {re, im}.
package cplx_pkg;

   localparam int DATA_W    = 24;
   localparam int FRAC_BITS = 12;
   localparam int CPLX_W    = 2 * DATA_W;
   localparam int NUM_W     = CPLX_W + 1;
   localparam int QUOT_W    = CPLX_W + FRAC_BITS;
   localparam int CNT_W     = $clog2(QUOT_W);

   localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;

   typedef enum logic [2:0] {
      IDLE,
      MULT,
      DIV,
      FINISH,
      HOLD
   } state_t;

   function automatic cplx_t unpack_cplx(input logic [CPLX_W-1:0] v);
      return cplx_t'(v);
   endfunction

   function automatic logic [CPLX_W-1:0] pack_cplx(
      input logic [DATA_W-1:0] re,
      input logic [DATA_W-1:0] im
   );
      return {re, im};
   endfunction

   // Reapply the sign to an unsigned magnitude, clamping to the data range.
   function automatic logic [DATA_W-1:0] sat_to_data(
      input logic              sign,
      input logic [QUOT_W-1:0] mag
   );
      logic [QUOT_W-1:0] lim;
      lim = QUOT_W'(1) << (DATA_W - 1);
      if (!sign)
         sat_to_data = (mag >= lim) ? MAX_POS : mag[DATA_W-1:0];
      else
         sat_to_data = (mag >= lim) ? MIN_NEG : -mag[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/complex_divider_serial_udivider.sv
// Unsigned restoring divider producing one quotient bit per step,
// MSB first. The remainder is always kept below the divisor.
module serial_udivider
   import cplx_pkg::*;
#(
   parameter int N_W = QUOT_W,
   parameter int D_W = CPLX_W
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic           step,
   input  logic           last,
   input  logic [N_W-1:0] num,
   input  logic [D_W-1:0] den,
   output logic [N_W-1:0] quot,
   output logic           done
);

   logic [D_W-1:0] rem;
   logic [N_W-1:0] q_sh;
   logic [D_W:0]   rem_sh;
   logic           ge;

   always_comb begin
      rem_sh = {rem, q_sh[N_W-1]};
      ge     = rem_sh >= {1'b0, den};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rem  <= '0;
         q_sh <= '0;
         done <= 1'b0;
      end else if (start) begin
         rem  <= '0;
         q_sh <= num;
         done <= 1'b0;
      end else if (step) begin
         rem  <= ge ? D_W'(rem_sh - {1'b0, den}) : D_W'(rem_sh);
         q_sh <= {q_sh[N_W-2:0], ge};
         if (last)
            done <= 1'b1;
      end
   end

   assign quot = q_sh;

endmodule

// File: rtl/complex_divider.sv
// Sequential complex divider q = a / b with valid/ready on both sides.
// Real and imaginary quotients share one denominator and one step counter.
module complex_divider
   import cplx_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CPLX_W-1:0] dividend,
   input  logic [CPLX_W-1:0] divisor,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CPLX_W-1:0] quotient,
   output logic              div_by_zero
);

   state_t state, state_nxt;

   cplx_t             a_q, b_q;
   logic [CPLX_W-1:0] den_q;
   logic              sgn_r, sgn_i, dz_q;
   logic [CNT_W-1:0]  cnt;

   logic signed [CPLX_W-1:0] ar, ai, br, bi;
   logic signed [NUM_W-1:0]  n_r, n_i;
   logic [CPLX_W-1:0]        den_c, mag_r, mag_i;

   logic [QUOT_W-1:0] quot_r, quot_i;
   logic              done_r, done_i, div_done;
   logic              last_step;

   always_comb begin
      ar    = CPLX_W'(a_q.re);
      ai    = CPLX_W'(a_q.im);
      br    = CPLX_W'(b_q.re);
      bi    = CPLX_W'(b_q.im);
      n_r   = NUM_W'(ar * br) + NUM_W'(ai * bi);
      n_i   = NUM_W'(ai * br) - NUM_W'(ar * bi);
      den_c = $unsigned(br * br) + $unsigned(bi * bi);
      mag_r = CPLX_W'(n_r[NUM_W-1] ? -n_r : n_r);
      mag_i = CPLX_W'(n_i[NUM_W-1] ? -n_i : n_i);
   end

   assign last_step = (cnt == CNT_W'(QUOT_W - 1));
   assign div_done  = done_r & done_i;

   serial_udivider u_div_r (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (state == MULT),
      .step    (state == DIV),
      .last    (last_step),
      .num     ({mag_r, {FRAC_BITS{1'b0}}}),
      .den     (den_q),
      .quot    (quot_r),
      .done    (done_r)
   );

   serial_udivider u_div_i (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (state == MULT),
      .step    (state == DIV),
      .last    (last_step),
      .num     ({mag_i, {FRAC_BITS{1'b0}}}),
      .den     (den_q),
      .quot    (quot_i),
      .done    (done_i)
   );

   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = MULT;
         end
         MULT:
            state_nxt = (den_c == '0) ? FINISH : DIV;
         DIV:
            if (last_step)
               state_nxt = FINISH;
         FINISH:
            state_nxt = HOLD;
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default:
            state_nxt = IDLE;
      endcase
   end

   // A zero divisor saturates each component toward the dividend's sign.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_q         <= '0;
         b_q         <= '0;
         den_q       <= '0;
         sgn_r       <= 1'b0;
         sgn_i       <= 1'b0;
         dz_q        <= 1'b0;
         cnt         <= '0;
         quotient    <= '0;
         div_by_zero <= 1'b0;
      end else begin
         unique case (state)
            IDLE:
               if (in_valid) begin
                  a_q         <= unpack_cplx(dividend);
                  b_q         <= unpack_cplx(divisor);
                  div_by_zero <= 1'b0;
               end
            MULT: begin
               den_q <= den_c;
               sgn_r <= n_r[NUM_W-1];
               sgn_i <= n_i[NUM_W-1];
               dz_q  <= (den_c == '0);
               cnt   <= '0;
            end
            DIV:
               cnt <= cnt + 1'b1;
            FINISH:
               if (dz_q) begin
                  quotient <= pack_cplx(
                     sat_to_data(a_q.re[DATA_W-1],
                                 (a_q.re == '0) ? '0 : '1),
                     sat_to_data(a_q.im[DATA_W-1],
                                 (a_q.im == '0) ? '0 : '1));
                  div_by_zero <= 1'b1;
               end else if (div_done) begin
                  quotient <= pack_cplx(sat_to_data(sgn_r, quot_r),
                                        sat_to_data(sgn_i, quot_i));
               end
            default: ;
         endcase
      end
   end

endmodule
